rr_index_arbiter: RTL and testbench



---
 rtl/rr_index_arbiter_pkg.sv | 13 +
 rtl/rr_index_arbiter_pick.sv | 32 +++
 rtl/rr_index_arbiter.sv | 86 ++++++++
 tb/tb_rr_index_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rr_index_arbiter_pkg.sv
// Shared definitions for the round-robin index arbiter: FSM state encoding
// and default sizing.
package rr_index_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int DEF_IDX_W    = 2;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// Rotating-priority scan: finds the first set request bit starting at ptr
// and wrapping modulo 2^IDX_W. Purely combinational.
module rr_pick
  import rr_index_arbiter_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [2**IDX_W-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic                any,
  output logic [IDX_W-1:0]    sel
);

  localparam int N = 2**IDX_W;

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit to ptr wins.
  always_comb begin
    any  = 1'b0;
    sel  = ptr;
    cand = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        sel = cand;
      end
    end
  end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter emitting a registered grant index plus enable for a
// downstream enable decoder. Define RR_TIMEOUT_EN to cap grants at MAX_HOLD cycles.
module rr_index_arbiter
  import rr_index_arbiter_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2**IDX_W-1:0] req,
  input  logic                done,
  output logic [IDX_W-1:0]    idx,
  output logic                en
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             pick_any;
  logic [IDX_W-1:0] pick_sel;
  logic             hold_expire;
  logic             release_now;

  rr_pick #(.IDX_W(IDX_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .sel (pick_sel)
  );

`ifdef RR_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_cnt;

  // Idle keeps the counter cleared, so it is zero on the first grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == ST_IDLE) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign hold_expire = (state == ST_GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  // No hold limit in this build; MAX_HOLD only matters with the timeout.
  assign hold_expire = (MAX_HOLD < 0);
`endif

  assign release_now = done || !req[idx] || hold_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      en    <= 1'b0;
      idx   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          en <= pick_any;
          if (pick_any) begin
            idx   <= pick_sel;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Returning to IDLE guarantees one en=0 cycle between grants.
          if (release_now) begin
            en    <= 1'b0;
            ptr   <= idx + IDX_W'(1);
            state <= ST_IDLE;
          end
        end
        default: begin
          en    <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: directed vector table, hand-written
// reset/hold sequences and randomized traffic against a behavioural model.
module tb_rr_index_arbiter;

  localparam int IDX_W    = 2;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic             done = 1'b0;
  logic [IDX_W-1:0] idx;
  logic             en;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural reference: grant holder, pointer and how long en has been high.
  int m_en, m_idx, m_ptr, m_hold;

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic         en;
    logic [1:0]   idx;
  } vec_t;

  vec_t tbl[21];

  rr_index_arbiter #(.IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .idx   (idx),
    .en    (en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #1;
    chk("reset_en", int'(en), 0);
    chk("reset_idx", int'(idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_en = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic d);
    bit rel;
    if (m_en == 0) begin
      for (int off = 0; off < N; off++) begin
        int j;
        j = (m_ptr + off) % N;
        if (m_en == 0 && r[j]) begin
          m_en = 1; m_idx = j; m_hold = 1;
        end
      end
    end else begin
      rel = d || !r[m_idx];
`ifdef RR_TIMEOUT_EN
      if (m_hold >= MAX_HOLD) rel = 1'b1;
`endif
      if (rel) begin
        m_en  = 0;
        m_ptr = (m_idx + 1) % N;
      end else begin
        m_hold++;
      end
    end
  endtask

  initial begin
    logic [N-1:0] r;
    logic         d;

    tbl[0]  = '{4'b0100, 1'b0, 1'b1, 2'd2};  // single request
    tbl[1]  = '{4'b0100, 1'b1, 1'b0, 2'd0};  // done -> ptr=3
    tbl[2]  = '{4'b0101, 1'b0, 1'b1, 2'd0};  // wrap-around picks 0, not 2
    tbl[3]  = '{4'b0101, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{4'b1111, 1'b0, 1'b1, 2'd1};  // fairness rotation
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 2'd0};
    tbl[6]  = '{4'b1111, 1'b0, 1'b1, 2'd2};
    tbl[7]  = '{4'b1111, 1'b1, 1'b0, 2'd0};
    tbl[8]  = '{4'b1111, 1'b0, 1'b1, 2'd3};
    tbl[9]  = '{4'b1111, 1'b1, 1'b0, 2'd0};
    tbl[10] = '{4'b1111, 1'b0, 1'b1, 2'd0};
    tbl[11] = '{4'b1111, 1'b1, 1'b0, 2'd0};
    tbl[12] = '{4'b0010, 1'b0, 1'b1, 2'd1};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 2'd0};  // request drop -> ptr=2
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 2'd0};  // done in idle ignored
    tbl[15] = '{4'b0010, 1'b0, 1'b1, 2'd1};
    tbl[16] = '{4'b1000, 1'b1, 1'b0, 2'd0};  // done + new request: release first
    tbl[17] = '{4'b1000, 1'b0, 1'b1, 2'd3};
    tbl[18] = '{4'b1000, 1'b0, 1'b1, 2'd3};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[20] = '{4'b0000, 1'b0, 1'b0, 2'd0};

    // Asynchronous reset mid-grant
    do_reset();
    step(4'b0100, 1'b0);
    chk("pre_reset_en", int'(en), 1);
    chk("pre_reset_idx", int'(idx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_en", int'(en), 0);
    chk("async_reset_idx", int'(idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      chk("post_reset_en", int'(en), 0);
    end

    // Directed table from a fresh reset
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].req, tbl[i].done);
      chk($sformatf("tbl%0d_en", i), int'(en), int'(tbl[i].en));
      if (tbl[i].en) chk($sformatf("tbl%0d_idx", i), int'(idx), int'(tbl[i].idx));
    end

    // Long hold on a single requester
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(4'b0001, 1'b0);
`ifdef RR_TIMEOUT_EN
      chk($sformatf("hold%0d_en", c), int'(en), (c != 8) ? 1 : 0);
`else
      chk($sformatf("hold%0d_en", c), int'(en), 1);
`endif
      if (en) chk($sformatf("hold%0d_idx", c), int'(idx), 0);
    end

    // Randomized traffic against the model
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) != 0) r = N'($urandom_range(0, N - 1) == 0 ? 0 : $urandom);
      if ($urandom_range(0, 2) == 0) r = r | N'(1 << m_idx);
      d = ($urandom_range(0, 4) == 0);
      step(r, d);
      model_edge(r, d);
      chk("rand_en", int'(en), m_en);
      if (m_en != 0) chk("rand_idx", int'(idx), m_idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
